// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: field widths, converter state encoding and word packing.
package fp32_pkg;

    localparam int FP32_BIAS = 127;
    localparam int EXP_W     = 8;
    localparam int MAN_W     = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    function automatic logic [31:0] pack_fp32(input logic             sign,
                                              input logic [EXP_W-1:0] exp,
                                              input logic [MAN_W-1:0] man);
        return {sign, exp, man};
    endfunction

endpackage

// File: rtl/int_to_fp32_if.sv
// Valid/ready operand and result channels of the integer-to-FP32 converter.
interface int_to_fp32_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/fp32_round.sv
// Packs a normalised 32-bit magnitude into {exp, man}, optionally rounding to nearest-even.
module fp32_round
    import fp32_pkg::*;
#(
    parameter bit ROUND_NEAREST = 1'b1
) (
    input  logic [31:0]            mag,
    input  logic [EXP_W-1:0]       exp_in,
    output logic [EXP_W+MAN_W-1:0] exp_man
);

    logic             guard;
    logic             sticky;
    logic             inc;
    logic [MAN_W:0]   man_sum;
    logic [EXP_W-1:0] exp_out;
    logic             unused_lead;

    // mag[31] is the implicit leading one and is never stored
    assign unused_lead = mag[31];

    always_comb begin
        guard   = mag[7];
        sticky  = |mag[6:0];
        inc     = ROUND_NEAREST && guard && (sticky || mag[8]);
        man_sum = {1'b0, mag[30:8]} + {{MAN_W{1'b0}}, inc};
        exp_out = exp_in;
        if (man_sum[MAN_W]) begin
            exp_out = exp_in + EXP_W'(1);
        end
        exp_man = {exp_out, man_sum[MAN_W-1:0]};
    end

endmodule

// File: rtl/int_to_fp32.sv
// Iterative integer to IEEE-754 single converter: shifts one bit per clock until
// the leading one reaches bit 31, then rounds and packs the result.
module int_to_fp32
    import fp32_pkg::*;
#(
    parameter bit SIGNED        = 1'b1,
    parameter bit ROUND_NEAREST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    int_to_fp32_if.slave bus
);

    localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(FP32_BIAS + 31);

    conv_state_e      state_q, state_d;
    logic             sign_q, sign_d;
    logic [31:0]      mag_q, mag_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             busy_q, busy_d;

    logic [EXP_W+MAN_W-1:0] rnd_exp_man;

    fp32_round #(
        .ROUND_NEAREST(ROUND_NEAREST)
    ) u_round (
        .mag    (mag_q),
        .exp_in (exp_q),
        .exp_man(rnd_exp_man)
    );

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        exp_d       = exp_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sign_d     = SIGNED && bus.in_data[31];
                    mag_d      = sign_d ? (32'd0 - bus.in_data) : bus.in_data;
                    exp_d      = EXP_INIT;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = NORM;
                end
            end
            NORM: begin
                if (mag_q[31]) begin
                    out_data_d  = pack_fp32(sign_q, rnd_exp_man[EXP_W+MAN_W-1:MAN_W],
                                            rnd_exp_man[MAN_W-1:0]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (mag_q == 32'd0) begin
                    // zero still spends one cycle here so its latency matches a normalised operand
                    out_data_d  = 32'd0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    mag_d = {mag_q[30:0], 1'b0};
                    exp_d = exp_q - EXP_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= 32'd0;
            exp_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_int_to_fp32.sv
// Directed bench for int_to_fp32: signed/nearest, unsigned/nearest and signed/truncate instances.
module tb_int_to_fp32;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    int_to_fp32_if if_a ();
    int_to_fp32_if if_u ();
    int_to_fp32_if if_t ();

    int_to_fp32 #(.SIGNED(1'b1), .ROUND_NEAREST(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    int_to_fp32 #(.SIGNED(1'b0), .ROUND_NEAREST(1'b1)) u_u (.clk(clk), .rst_n(rst_n), .bus(if_u));
    int_to_fp32 #(.SIGNED(1'b1), .ROUND_NEAREST(1'b0)) u_t (.clk(clk), .rst_n(rst_n), .bus(if_t));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_ov(input int w);
        case (w)
            0:       return if_a.out_valid;
            1:       return if_u.out_valid;
            default: return if_t.out_valid;
        endcase
    endfunction

    function automatic logic [31:0] get_od(input int w);
        case (w)
            0:       return if_a.out_data;
            1:       return if_u.out_data;
            default: return if_t.out_data;
        endcase
    endfunction

    function automatic logic get_ir(input int w);
        case (w)
            0:       return if_a.in_ready;
            1:       return if_u.in_ready;
            default: return if_t.in_ready;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0:       return if_a.busy;
            1:       return if_u.busy;
            default: return if_t.busy;
        endcase
    endfunction

    task automatic set_in(input int w, input logic v, input logic [31:0] d);
        case (w)
            0:       begin if_a.in_valid = v; if_a.in_data = d; end
            1:       begin if_u.in_valid = v; if_u.in_data = d; end
            default: begin if_t.in_valid = v; if_t.in_data = d; end
        endcase
    endtask

    task automatic set_or(input int w, input logic r);
        case (w)
            0:       if_a.out_ready = r;
            1:       if_u.out_ready = r;
            default: if_t.out_ready = r;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called right after the accept edge (+#1); waits for the result, compares, then drains it.
    task automatic wait_result(input int w, input int lat_exp, input string tag);
        int lat;
        bit seen;
        logic [31:0] e;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            if (get_ov(w)) seen = 1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        chk({tag, "_timeout"}, 32'(seen), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        if (seen) begin
            if (lat_exp >= 0) chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
            chk({tag, "_data"}, get_od(w), e);
            chk({tag, "_busy"}, 32'(get_busy(w)), 32'd1);
        end
        set_or(w, 1'b1);
        @(posedge clk); #1;
        set_or(w, 1'b0);
        chk({tag, "_drain_ov"}, 32'(get_ov(w)), 32'd0);
        chk({tag, "_drain_ir"}, 32'(get_ir(w)), 32'd1);
    endtask

    task automatic convert(input int w, input logic [31:0] d, input logic [31:0] e,
                           input int lat_exp, input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, 32'(get_ir(w)), 32'd1);
        set_in(w, 1'b1, d);
        sb.push_back(e);
        @(posedge clk); #1;
        set_in(w, 1'b0, ~d);
        wait_result(w, lat_exp, tag);
    endtask

    initial begin
        logic [31:0] held;
        bit seen;
        int n;

        rst_n = 1'b0;
        for (int w = 0; w < 3; w++) begin
            set_in(w, 1'b0, 32'd0);
            set_or(w, 1'b0);
        end
        #22;
        chk("rst_in_ready", 32'(if_a.in_ready), 32'd1);
        chk("rst_out_valid", 32'(if_a.out_valid), 32'd0);
        chk("rst_out_data", if_a.out_data, 32'd0);
        chk("rst_busy", 32'(if_a.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // out_ready with nothing to deliver must be ignored
        set_or(0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_or_ov", 32'(if_a.out_valid), 32'd0);
        chk("idle_or_ir", 32'(if_a.in_ready), 32'd1);
        set_or(0, 1'b0);

        convert(0, 32'h0000_0001, 32'h3F80_0000, 32, "one");
        convert(0, 32'hFFFF_FFFF, 32'hBF80_0000, 32, "minus_one");
        convert(0, 32'h8000_0000, 32'hCF00_0000, 1, "int_min_s");
        convert(1, 32'h8000_0000, 32'h4F00_0000, 1, "int_min_u");
        convert(1, 32'hFFFF_FFFF, 32'h4F80_0000, 1, "umax_carry");
        convert(0, 32'h0100_0003, 32'h4B80_0002, 8, "rne_up");
        convert(0, 32'h7FFF_FFFF, 32'h4F00_0000, 2, "rne_carry");
        convert(0, 32'h0100_0001, 32'h4B80_0000, 8, "rne_tie_even");
        convert(2, 32'h0100_0003, 32'h4B80_0001, 8, "trunc_a");
        convert(2, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 2, "trunc_b");
        convert(0, 32'h0000_0000, 32'h0000_0000, 1, "zero");
        convert(2, 32'hFFFF_FFFB, 32'hC0A0_0000, 30, "minus_five");

        // backpressure: result held for 10 cycles while a new request is offered
        @(negedge clk);
        set_in(0, 1'b1, 32'd5);
        sb.push_back(32'h40A0_0000);
        @(posedge clk); #1;
        set_in(0, 1'b0, 32'd0);
        seen = 0;
        n = 0;
        while (!seen && n < 40) begin
            if (if_a.out_valid) seen = 1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("bp_timeout", 32'(seen), 32'd1);
        chk("bp_data", if_a.out_data, sb.pop_front());
        held = if_a.out_data;
        set_in(0, 1'b1, 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_ov", 32'(if_a.out_valid), 32'd1);
            chk("bp_hold_od", if_a.out_data, held);
            chk("bp_hold_ir", 32'(if_a.in_ready), 32'd0);
        end
        @(negedge clk);
        set_in(0, 1'b1, 32'd3);
        set_or(0, 1'b1);
        @(posedge clk); #1;
        set_or(0, 1'b0);
        chk("bp_rel_ov", 32'(if_a.out_valid), 32'd0);
        chk("bp_rel_ir", 32'(if_a.in_ready), 32'd1);
        chk("bp_rel_busy", 32'(if_a.busy), 32'd0);
        sb.push_back(32'h4040_0000);
        @(posedge clk); #1;
        set_in(0, 1'b0, 32'd0);
        chk("bp_accept_ir", 32'(if_a.in_ready), 32'd0);
        wait_result(0, 31, "bp_next");

        // reset in the middle of normalisation drops the transaction
        @(negedge clk);
        set_in(0, 1'b1, 32'd1);
        sb.push_back(32'h3F80_0000);
        @(posedge clk); #1;
        set_in(0, 1'b0, 32'd0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ir", 32'(if_a.in_ready), 32'd1);
        chk("mid_rst_ov", 32'(if_a.out_valid), 32'd0);
        chk("mid_rst_od", if_a.out_data, 32'd0);
        chk("mid_rst_busy", 32'(if_a.busy), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_out", 32'(if_a.out_valid), 32'd0);
        end
        convert(0, 32'h0000_0003, 32'h4040_0000, 31, "three");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/int_to_fp32.md
Name: int_to_fp32

Overview:
- Iterative converter from a 32-bit integer to an IEEE-754 single-precision word; it produces operands for the team's combinational FP32 adder.
- Normalises one bit per clock under an FSM, then packs sign, exponent and mantissa.
- Valid/ready handshake on both sides; one conversion in flight at a time.

Parameters:
SIGNED, 1, 1 = in_data is two's-complement; 0 = in_data is unsigned.
ROUND_NEAREST, 1, 1 = round-to-nearest-even; 0 = truncate, matching the adder's truncating datapath.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data is valid
in_ready  output  1  converter can accept; high only in IDLE
in_data  input  32  integer operand
out_valid  output  1  out_data is valid; held until accepted
out_ready  input  1  downstream accepts out_data
out_data  output  32  result as {sign, exp[7:0], man[22:0]}
busy  output  1  high in NORM or DONE

Behaviour:
- Reset, asynchronous: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0. All internal registers clear. Asserting reset mid-conversion drops the transaction; nothing is emitted.
- FSM states are IDLE, NORM and DONE.
- IDLE, on in_valid&&in_ready (accept edge):
  - sign = SIGNED & in_data[31].
  - mag[31:0] = sign ? -in_data : in_data. For SIGNED, 0x80000000 gives 0x80000000 and is not an error.
  - exp = 158 (bias 127 + 31).
  - If mag==0: out_data=0x00000000 with positive sign, then go to DONE.
  - Otherwise go to NORM.
- NORM, each cycle:
  - If !mag[31]: mag <<= 1 and exp -= 1.
  - Else pack and go to DONE:
    - man = mag[30:8], guard = mag[7], sticky = |mag[6:0].
    - If ROUND_NEAREST and guard&(sticky|man[0]): man += 1.
    - Mantissa carry-out sets man=0 and exp+=1.
    - out_data = {sign, exp, man}.
- DONE: out_valid=1 and out_data is stable. On out_ready, go to IDLE with out_valid=0 at the next edge.
- Latency: with k = leading zeros of mag (0..31), out_valid rises k+1 cycles after the accept edge.
  - Zero input: 1 cycle.
  - Maximum: 32 cycles (mag=1).
- Throughput: no overlap. in_ready is low from the accept edge until the cycle after out_ready is sampled in DONE.
- in_valid while not ready is ignored. in_data is sampled only at the accept edge, so later input changes have no effect.
- out_ready while out_valid=0 is ignored.
- Exponent arithmetic is 8-bit unsigned. Its range is 127..159, so no underflow, overflow, infinity or NaN can occur.
- Rounding carry into bit 31 is impossible, since the maximum result is 2^32 giving exp 159.

Decomposition:
- Shared package fp32_pkg holds:
  - FP32_BIAS=127, EXP_W=8, MAN_W=23.
  - The state encoding enum (IDLE, NORM, DONE).
  - A helper that packs a word from sign, exp and man.
- One sub-module, fp32_round: combinational. It takes the normalised 32-bit magnitude plus exp and ROUND_NEAREST, and returns {exp, man}. This lets the adder reuse it later.
- FSM, shifter and handshake stay in int_to_fp32.

Test Plan:
- SIGNED=1, in_data=1 -> out_data=0x3F800000, out_valid exactly 32 cycles after accept. in_data=0xFFFFFFFF -> 0xBF800000.
- SIGNED=1, in_data=0x80000000 -> 0xCF000000, latency 1. SIGNED=0 with the same input -> 0x4F000000.
- ROUND_NEAREST=1: 0x01000003 -> 0x4B800002; 0x7FFFFFFF -> 0x4F000000. ROUND_NEAREST=0: same inputs -> 0x4B800001 and 0x4EFFFFFF.
- in_data=0 -> out_data=0x00000000 after 1 cycle. Any signed negative zero input still yields sign 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, a new in_valid is not accepted. Release -> the next op is accepted only after IDLE is re-entered.
- Deassert rst_n mid-NORM, e.g. 5 cycles into converting 1 -> all outputs return to reset values immediately. After release, no stale result appears, and the next conversion of 3 -> 0x40400000.
